// File: rtl/subarashii_pkg.sv
// Shared definitions for the program loader: loader FSM state encoding,
// instruction word geometry and a small state-classification helper.
package subarashii_pkg;

    localparam int WORD_W      = 16;
    localparam int INSTR_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        CHECK   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } loader_state_t;

    // States in which a frame is in flight and bytes are consumed.
    function automatic logic state_is_busy(input loader_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
               (s == DATA_LO) || (s == CHECK);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Datapath half of the program loader.
// Collects the hi byte of each instruction word, emits a one-cycle write of
// {hi,lo} when the lo byte arrives, generates the word address from the word
// index and keeps the running XOR of all data bytes.
// Ports:
//   clk, rst      clock, async active-high reset
//   clear         start of a new frame: zero index and checksum
//   hi_load       a hi data byte is being accepted this cycle
//   lo_load       a lo data byte is being accepted this cycle
//   data          stream byte
//   mem_wen       write strobe, one cycle per word
//   mem_addr      write byte address, BASE_ADDR + 2*index (wraps at 16 bits)
//   mem_wdata     write word {hi,lo}
//   words_loaded  words written so far; doubles as the index of the next word
//   acc           XOR of all data bytes accepted in this frame
module byte_packer
    import subarashii_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              hi_load,
    input  logic              lo_load,
    input  logic [7:0]        data,
    output logic              mem_wen,
    output logic [15:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [15:0]       words_loaded,
    output logic [7:0]        acc
);

    logic [7:0] hi_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_byte      <= 8'h00;
            mem_wen      <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            words_loaded <= 16'h0000;
            acc          <= 8'h00;
        end else begin
            mem_wen <= 1'b0;
            if (clear) begin
                words_loaded <= 16'h0000;
                acc          <= 8'h00;
            end else begin
                if (hi_load) begin
                    hi_byte <= data;
                    acc     <= acc ^ data;
                end
                if (lo_load) begin
                    // The write uses the index before it is bumped, so the
                    // address and the incremented count land on the same edge.
                    mem_wen      <= 1'b1;
                    mem_wdata    <= {hi_byte, data};
                    mem_addr     <= BASE_ADDR + 16'(INSTR_BYTES) * words_loaded;
                    words_loaded <= words_loaded + 16'h0001;
                    acc          <= acc ^ data;
                end
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Writer side of the instruction-memory interface. Receives a framed program
// (length, data words, XOR checksum) over a valid/ready byte stream, writes
// each 16-bit big-endian word to the instruction ROM write port and holds the
// CPU in reset until a load has been verified.
// Ports:
//   clk, rst      clock, async active-high reset
//   start         one-cycle pulse, begins a load from IDLE, DONE or ERROR
//   in_data       stream byte
//   in_valid      in_data valid
//   in_ready      loader accepts a byte this cycle
//   mem_wen       write enable, one-cycle pulse per word
//   mem_addr      write byte address
//   mem_wdata     write word {hi,lo}
//   cpu_rst       CPU reset, low only while DONE (registered)
//   busy          frame in progress (LEN_HI..CHECK)
//   done          verified load complete
//   error         oversize header or checksum mismatch
//   words_loaded  words written in the current/last load
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for start
// LEN_HI  | expecting word-count high byte
// LEN_LO  | expecting word-count low byte
// DATA_HI | expecting high byte of next word
// DATA_LO | expecting low byte, triggers the write
// CHECK   | expecting checksum byte
// DONE    | program verified, CPU released
// ERROR   | bad length or checksum, CPU held in reset
module prog_loader
    import subarashii_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_wen,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

    loader_state_t state, state_next;

    logic [7:0]  len_hi;
    logic [15:0] n_words;
    logic [15:0] len_full;
    logic [7:0]  acc;
    logic        xfer;
    logic        clear;
    logic        hi_load;
    logic        lo_load;

    assign xfer     = in_valid & in_ready;
    assign len_full = {len_hi, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len_hi  <= 8'h00;
            n_words <= 16'h0000;
            cpu_rst <= 1'b1;
        end else begin
            state <= state_next;
            if (state == LEN_HI && xfer) begin
                len_hi <= in_data;
            end
            if (state == LEN_LO && xfer) begin
                n_words <= len_full;
            end
            // Released only after a full cycle in DONE; any exit from DONE
            // reasserts it on the leaving edge.
            cpu_rst <= !((state == DONE) && (state_next == DONE));
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        clear      = 1'b0;
        hi_load    = 1'b0;
        lo_load    = 1'b0;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_next = LEN_HI;
                    clear      = 1'b1;
                end
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) state_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (len_full == 16'h0000)
                        state_next = CHECK;
                    else if ({1'b0, len_full} > MAX_WORDS_W)
                        state_next = ERROR;
                    else
                        state_next = DATA_HI;
                end
            end
            DATA_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    hi_load    = 1'b1;
                    state_next = DATA_LO;
                end
            end
            DATA_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    lo_load = 1'b1;
                    // words_loaded has not yet counted the word being accepted.
                    if (words_loaded + 16'h0001 == n_words)
                        state_next = CHECK;
                    else
                        state_next = DATA_HI;
                end
            end
            CHECK: begin
                in_ready = 1'b1;
                if (xfer) state_next = (in_data == acc) ? DONE : ERROR;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy  = state_is_busy(state);
    assign done  = (state == DONE);
    assign error = (state == ERROR);

    byte_packer #(
        .BASE_ADDR (BASE_ADDR)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .hi_load      (hi_load),
        .lo_load      (lo_load),
        .data         (in_data),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .words_loaded (words_loaded),
        .acc          (acc)
    );

endmodule
